// File: rtl/truth_table_checker_pkg.sv
// Shared definitions for the truth-table checker family: state encoding and
// table-width derivation.
package truth_table_checker_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int tw_of(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/settle_counter.sv
// Down-counter with synchronous load and a zero flag; it paces how long each
// minterm is held on the DUT before sampling.
module settle_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && cnt_q != '0)
      cnt_d = cnt_q - WIDTH'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Walks every minterm onto a combinational DUT, samples its output after a
// settle time and scores the captured table against an expected one.
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter  int N_IN   = 2,
  parameter  int SETTLE = 1,
  localparam int TW     = tw_of(N_IN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [TW-1:0]   expected,
  input  logic            dut_s,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [TW-1:0]   table_q,
  output logic [N_IN:0]   fail_count,
  output logic [N_IN-1:0] first_fail
);

  localparam int              CW          = $clog2(SETTLE) + 1;
  localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] STIM_LAST   = N_IN'(TW - 1);
  localparam logic [N_IN-1:0] STIM_ONE    = N_IN'(1);
  localparam logic [N_IN:0]   FAIL_ONE    = (N_IN + 1)'(1);

  if (SETTLE < 1) begin : g_settle_check
    $error("truth_table_checker: SETTLE must be >= 1");
  end

  state_e          state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [TW-1:0]   exp_q, exp_d;
  logic [TW-1:0]   table_d;
  logic [N_IN:0]   fail_count_q, fail_count_d;
  logic [N_IN-1:0] first_fail_q, first_fail_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            cnt_load, cnt_dec, cnt_zero;
  logic            mismatch;

  settle_counter #(.WIDTH(CW)) u_settle (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign mismatch = (dut_s != exp_q[stim_q]);

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    stim_d       = stim_q;
    exp_d        = exp_q;
    table_d      = table_q;
    fail_count_d = fail_count_q;
    first_fail_d = first_fail_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        stim_d = '0;
        if (start) begin
          exp_d        = expected;
          table_d      = '0;
          fail_count_d = '0;
          first_fail_d = '0;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
          cnt_load     = 1'b1;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          table_d[stim_q] = dut_s;
          // An empty fail count means this is the run's first mismatch.
          if (mismatch) begin
            fail_count_d = fail_count_q + FAIL_ONE;
            if (fail_count_q == '0) first_fail_d = stim_q;
          end
          if (stim_q == STIM_LAST) begin
            pass_d  = (fail_count_q == '0) && !mismatch;
            stim_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            stim_d   = stim_q + STIM_ONE;
            cnt_load = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      stim_q       <= '0;
      exp_q        <= '0;
      table_q      <= '0;
      fail_count_q <= '0;
      first_fail_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      stim_q       <= stim_d;
      exp_q        <= exp_d;
      table_q      <= table_d;
      fail_count_q <= fail_count_d;
      first_fail_q <= first_fail_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign stim       = stim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_count = fail_count_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench: three checker configurations, each driving a
// table-defined responder, scored against a truth-table reference model.
module tb_truth_table_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Instance A: N_IN=2, SETTLE=1
  logic       start_a, dut_s_a, busy_a, done_a, pass_a;
  logic [3:0] exp_a, fn_a, table_a;
  logic [1:0] stim_a, ff_a;
  logic [2:0] fc_a;
  // Instance B: N_IN=2, SETTLE=3
  logic       start_b, dut_s_b, busy_b, done_b, pass_b;
  logic [3:0] exp_b, fn_b, table_b;
  logic [1:0] stim_b, ff_b;
  logic [2:0] fc_b;
  // Instance C: N_IN=3, SETTLE=2
  logic       start_c, dut_s_c, busy_c, done_c, pass_c;
  logic [7:0] exp_c, fn_c, table_c;
  logic [2:0] stim_c, ff_c;
  logic [3:0] fc_c;

  assign dut_s_a = fn_a[stim_a];
  assign dut_s_b = fn_b[stim_b];
  assign dut_s_c = fn_c[stim_c];

  truth_table_checker #(.N_IN(2), .SETTLE(1)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .expected(exp_a), .dut_s(dut_s_a),
    .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a), .table_q(table_a),
    .fail_count(fc_a), .first_fail(ff_a));

  truth_table_checker #(.N_IN(2), .SETTLE(3)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .expected(exp_b), .dut_s(dut_s_b),
    .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b), .table_q(table_b),
    .fail_count(fc_b), .first_fail(ff_b));

  truth_table_checker #(.N_IN(3), .SETTLE(2)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .expected(exp_c), .dut_s(dut_s_c),
    .stim(stim_c), .busy(busy_c), .done(done_c), .pass(pass_c), .table_q(table_c),
    .fail_count(fc_c), .first_fail(ff_c));

  int         sel = 0;
  logic [2:0] o_stim, o_ff;
  logic [7:0] o_table;
  logic [3:0] o_fc;
  logic       o_busy, o_done, o_pass;

  always_comb begin
    o_stim = '0; o_ff = '0; o_table = '0; o_fc = '0;
    o_busy = 1'b0; o_done = 1'b0; o_pass = 1'b0;
    case (sel)
      0: begin
        o_stim = {1'b0, stim_a}; o_ff = {1'b0, ff_a}; o_table = {4'h0, table_a};
        o_fc = {1'b0, fc_a}; o_busy = busy_a; o_done = done_a; o_pass = pass_a;
      end
      1: begin
        o_stim = {1'b0, stim_b}; o_ff = {1'b0, ff_b}; o_table = {4'h0, table_b};
        o_fc = {1'b0, fc_b}; o_busy = busy_b; o_done = done_b; o_pass = pass_b;
      end
      default: begin
        o_stim = stim_c; o_ff = ff_c; o_table = table_c;
        o_fc = fc_c; o_busy = busy_c; o_done = done_c; o_pass = pass_c;
      end
    endcase
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int tw_sel(input int s);
    return (s == 2) ? 8 : 4;
  endfunction

  function automatic int settle_sel(input int s);
    return (s == 0) ? 1 : (s == 1) ? 3 : 2;
  endfunction

  task automatic drive_start(input logic v);
    case (sel)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic set_exp(input logic [7:0] e);
    case (sel)
      0:       exp_a = e[3:0];
      1:       exp_b = e[3:0];
      default: exp_c = e;
    endcase
  endtask

  task automatic set_fn(input logic [7:0] f);
    case (sel)
      0:       fn_a = f[3:0];
      1:       fn_b = f[3:0];
      default: fn_c = f;
    endcase
  endtask

  // Reference: the captured table is the responder's function; the score
  // comes from the positions where it disagrees with the expected table.
  task automatic model(input logic [7:0] fn, input logic [7:0] ex, input int tw,
                       output logic [7:0] m_table, output logic [3:0] m_fc,
                       output logic [2:0] m_ff, output logic m_pass);
    logic [7:0] mask, diff;
    mask    = (tw == 8) ? 8'hFF : 8'h0F;
    m_table = fn & mask;
    diff    = (fn ^ ex) & mask;
    m_fc    = '0;
    m_ff    = '0;
    for (int i = tw - 1; i >= 0; i--) begin
      if (diff[i]) begin
        m_fc = m_fc + 4'd1;
        m_ff = 3'(i);
      end
    end
    m_pass = (diff == 8'h00);
  endtask

  task automatic check_results(input string tag, input logic [7:0] m_table, input logic [3:0] m_fc,
                               input logic [2:0] m_ff, input logic m_pass);
    check({tag, "_table"}, o_table, m_table);
    check({tag, "_fc"},    o_fc,    m_fc);
    check({tag, "_ff"},    o_ff,    m_ff);
    check({tag, "_pass"},  o_pass,  m_pass);
  endtask

  // One full run on instance s. poke: stray starts mid-run and in the DONE
  // cycle plus a mid-run change of expected. hold: start held for back-to-back.
  task automatic run(input int s, input logic [7:0] fn, input logic [7:0] ex,
                     input bit poke, input bit hold, input string tag);
    int         st, last;
    logic [7:0] m_table;
    logic [3:0] m_fc;
    logic [2:0] m_ff;
    logic       m_pass;
    sel  = s;
    st   = settle_sel(s);
    last = tw_sel(s) * st;
    model(fn, ex, tw_sel(s), m_table, m_fc, m_ff, m_pass);
    set_fn(fn);
    set_exp(ex);
    drive_start(1'b1);
    tick();
    if (!hold) drive_start(1'b0);
    check({tag, "_busy_start"}, o_busy, 1);
    check({tag, "_stim_start"}, o_stim, 0);
    for (int k = 1; k <= last + 2; k++) begin
      tick();
      if (k < last) begin
        check({tag, "_stim"}, o_stim, k / st);
        check({tag, "_busy"}, o_busy, 1);
        check({tag, "_done_early"}, o_done, 0);
      end else if (k == last) begin
        check({tag, "_done"}, o_done, 1);
        check({tag, "_busy_end"}, o_busy, 0);
        check({tag, "_stim_end"}, o_stim, 0);
        check_results(tag, m_table, m_fc, m_ff, m_pass);
      end else if (k == last + 1) begin
        check({tag, "_done_once"}, o_done, 0);
        check({tag, "_busy_gap"}, o_busy, 0);
        check_results({tag, "_held"}, m_table, m_fc, m_ff, m_pass);
      end else begin
        check({tag, "_busy_after"}, o_busy, hold ? 1 : 0);
        check({tag, "_done_after"}, o_done, 0);
      end
      if (poke) begin
        if (k == 1) begin drive_start(1'b1); set_exp(~ex); end
        if (k == 2) drive_start(1'b0);
        if (k == last) drive_start(1'b1);
        if (k == last + 1) drive_start(1'b0);
      end
    end
    if (hold) begin
      drive_start(1'b0);
      for (int j = 1; j <= last; j++) begin
        tick();
        if (j < last) check({tag, "_b2b_done_early"}, o_done, 0);
      end
      check({tag, "_b2b_done"}, o_done, 1);
      check_results({tag, "_b2b"}, m_table, m_fc, m_ff, m_pass);
      tick();
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_stim"},  o_stim,  0);
    check({tag, "_busy"},  o_busy,  0);
    check({tag, "_done"},  o_done,  0);
    check({tag, "_pass"},  o_pass,  0);
    check({tag, "_table"}, o_table, 0);
    check({tag, "_fc"},    o_fc,    0);
    check({tag, "_ff"},    o_ff,    0);
  endtask

  initial begin
    reset   = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    exp_a = '0; exp_b = '0; exp_c = '0;
    fn_a  = '0; fn_b  = '0; fn_c  = '0;
    tick();
    tick();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      check_cleared("reset_state");
    end
    reset = 1'b0;
    tick();

    run(0, 8'h0D, 8'h0D, 0, 0, "f5_good");
    run(0, 8'h08, 8'h0D, 0, 0, "f5_faulty");
    run(1, 8'h0D, 8'h0D, 0, 0, "f5_settle3");
    run(0, 8'h0D, 8'h0D, 1, 0, "start_ignored");
    run(0, 8'h0D, 8'h0D, 0, 1, "start_held");
    run(2, 8'hE8, 8'hE8, 0, 0, "maj_good");
    run(2, 8'hE8, 8'hE9, 0, 0, "maj_bad");
    run(0, 8'h00, 8'h0F, 0, 0, "all_fail_tw4");
    run(2, 8'h00, 8'hFF, 0, 0, "all_fail_tw8");

    // Reset asserted at edge 2 of a run aborts it with nothing kept.
    sel = 0;
    set_fn(8'h0D);
    set_exp(8'h0D);
    drive_start(1'b1);
    tick();
    drive_start(1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_cleared("reset_midrun");
    for (int k = 0; k < 4; k++) begin
      tick();
      check("reset_no_done", o_done, 0);
      check("reset_idle", o_busy, 0);
    end
    run(0, 8'h0D, 8'h0D, 0, 0, "after_reset");

    for (int i = 0; i < 20; i++) begin
      int         s;
      logic [7:0] fn, ex;
      s  = int'($urandom_range(0, 2));
      fn = 8'($urandom);
      ex = ($urandom_range(0, 1) == 1) ? fn : 8'($urandom);
      run(s, fn, ex, bit'($urandom_range(0, 1)), 1'b0, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Sequential stimulus/response engine for small combinational gate modules, such as 2-input f-functions.
- Drives every minterm onto the DUT inputs in ascending order and samples the DUT output after a programmable settle time.
- Builds the measured truth table and compares it bit-by-bit against an expected table.
- Replaces hand-written #delay stimulus lists: the checker is the driving end, and the gate module is the responder.

Parameters:
- N_IN, 2, number of DUT inputs. Table width TW = 2**N_IN.
- SETTLE, 1, cycles each minterm is held before sampling. Must be >= 1; SETTLE = 0 is an elaboration error.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request a run; sampled only in IDLE
- expected  in  TW  expected table; bit m = output for minterm m; latched on accepted start
- dut_s  in  1  DUT output, combinational from stim
- stim  out  N_IN  minterm driven to the DUT; bit N_IN-1 = first operand (a), bit 0 = last (b)
- busy  out  1  high while a run is in progress
- done  out  1  one-cycle pulse at run end
- pass  out  1  1 when no mismatches; valid from done, held until next accepted start
- table_q  out  TW  captured table; bit m = dut_s sampled for minterm m
- fail_count  out  N_IN+1  number of mismatching minterms
- first_fail  out  N_IN  lowest mismatching minterm; 0 if none

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - state = IDLE.
  - stim, busy, done, pass, table_q, fail_count, first_fail all = 0.
  - Reset mid-run aborts the run: no done pulse and no partial results kept.
- States: IDLE, RUN, DONE. Encoding is 2-bit.
- IDLE:
  - On start = 1: latch expected into exp_q; clear table_q, fail_count, first_fail, pass; stim = 0; cnt = SETTLE-1; busy = 1; go to RUN.
  - On start = 0: stay in IDLE, stim = 0.
- RUN, cnt != 0: cnt decrements; stim is held.
- RUN, cnt == 0 (sample edge):
  - table_q[stim] <= dut_s.
  - On mismatch (dut_s != exp_q[stim]): fail_count += 1. If this is the first mismatch of the run, first_fail <= stim.
  - If stim == TW-1: go to DONE. Set pass <= (no mismatch over the whole run, including this sample). Set stim <= 0.
  - Otherwise: stim += 1 and cnt = SETTLE-1.
- DONE (exactly one cycle): done = 1, busy = 0, then go to IDLE. Results are held.
- Latency:
  - With start sampled at edge 0, minterm m is sampled at edge (m+1)*SETTLE.
  - done is high for the cycle after edge TW*SETTLE.
  - busy is high for TW*SETTLE cycles.
- Boundaries:
  - start is ignored in RUN and DONE; it is not queued.
  - start held high gives back-to-back runs, with one IDLE cycle between done and the next busy.
  - exp_q is stable for the whole run even if expected changes mid-run.
  - fail_count can reach TW without overflow, which is why it is N_IN+1 bits wide.
  - stim never exceeds TW-1.
  - All outputs are registered.

Decomposition:
- Shared package: state encoding localparams (S_IDLE = 0, S_RUN = 1, S_DONE = 2) and the TW derivation, reused by later checker blocks.
- One natural sub-module: settle_counter, a down-counter with load and zero flag, width clog2(SETTLE)+1. The rest stays in a single module.

Test Plan:
- Good f5 DUT (dut_s = stim[1] | ~stim[0]), expected = 4'b1101, SETTLE = 1, start pulsed at edge 0 -> stim steps 0, 1, 2, 3; done at the cycle after edge 4; table_q = 1101, pass = 1, fail_count = 0, first_fail = 0.
- Faulty DUT (dut_s = stim[1] & stim[0]), expected = 4'b1101 -> table_q = 1000, fail_count = 2, first_fail = 0, pass = 0.
- SETTLE = 3, good f5 DUT -> each stim value held 3 cycles; samples at edges 3, 6, 9, 12; done after edge 12; pass = 1.
- Reset asserted at edge 2 of a run -> next cycle all outputs are 0 and state is IDLE, with no done pulse; a following start completes with pass = 1.
- start pulsed during RUN and during the DONE cycle -> ignored, exactly one done. start held high -> second run begins with busy rising one cycle after done.
- N_IN = 3, majority DUT, expected = 8'hE8 -> 8 samples, table_q = 8'hE8, pass = 1. With expected = 8'hE9 -> fail_count = 1, first_fail = 0, pass = 0.
